// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store,
// one fixed-latency access outstanding at a time. Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy
);

  // Handshake: a requester holds req and its command stable until it sees its
  // one-cycle gnt; the matching rvalid pulse arrives MEM_LAT+1 cycles after gnt.

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  state_t            state_q;
  logic [2:0]        lat_q;
  logic              owner_d_q;
  logic              owner_we_q;
  logic              if_gnt_q, d_gnt_q, mem_en_q, mem_we_q, busy_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [WIDTH-1:0]  if_rdata_q, d_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_d_q;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]        starve_q;
`endif

  logic last_wait, arb_slot, arb_go, both, fetch_wins;

  always_comb begin
    last_wait = (state_q == S_WAIT) && (lat_q == LAT_LAST);
    arb_slot  = (state_q == S_IDLE) || last_wait;
    arb_go    = arb_slot && (if_req || d_req);
    both      = if_req && d_req;
`ifdef ARB_ROUND_ROBIN_EN
    fetch_wins = both ? last_d_q : if_req;
`else
    fetch_wins = both ? (starve_q == STARVE_LIM) : if_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      owner_d_q   <= 1'b0;
      owner_we_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b1;
`else
      starve_q    <= '0;
`endif
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;

      // Memory data is valid in the final WAIT cycle; route it to the owner.
      if (last_wait) begin
        if (owner_d_q) begin
          d_rvalid_q <= 1'b1;
          if (!owner_we_q) d_rdata_q <= mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_rdata;
        end
      end else if (state_q == S_WAIT) begin
        lat_q <= lat_q + 3'd1;
      end

      if (arb_go) begin
        state_q   <= S_WAIT;
        busy_q    <= 1'b1;
        lat_q     <= '0;
        mem_en_q  <= 1'b1;
        owner_d_q <= !fetch_wins;
        if (fetch_wins) begin
          if_gnt_q   <= 1'b1;
          mem_addr_q <= if_addr;
          mem_we_q   <= 1'b0;
          owner_we_q <= 1'b0;
        end else begin
          d_gnt_q     <= 1'b1;
          mem_addr_q  <= d_addr;
          mem_we_q    <= d_we;
          mem_wdata_q <= d_wdata;
          owner_we_q  <= d_we;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d_q <= !fetch_wins;
`else
        // Count consecutive conflicts lost by fetch; any other outcome clears.
        if (both && !fetch_wins) begin
          if (starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
        end else begin
          starve_q <= '0;
        end
`endif
      end else if (arb_slot) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios then random traffic, checked
// every cycle against a transaction-level model of arbitration, latency and routing.
module tb_mem_port_arbiter;
  localparam int WIDTH      = 32;
  localparam int ADDR_W     = 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [WIDTH-1:0]  d_wdata = '0;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [WIDTH-1:0]  if_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int               cyc;
    bit               is_data;
    bit               we;
    logic [WIDTH-1:0] data;
  } comp_t;

  comp_t            exp_q[$];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               c = 0;
  int               n_vec = 0;
  int               n_err = 0;
  int               last_iss, next_arb, starve;
  bit               iss_data, iss_we, rr_last_data;
  logic [ADDR_W-1:0] exp_addr;
  logic [WIDTH-1:0] exp_wdata, exp_if_rdata, exp_d_rdata;
  int               rd_due = -1;
  logic [WIDTH-1:0] rd_val = '0;
  bit               rand_mode = 1'b0, if_keep = 1'b0, d_keep = 1'b0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    last_iss     = -100;
    next_arb     = 0;
    starve       = 0;
    rr_last_data = 1'b1;
    exp_addr     = '0;
    exp_wdata    = '0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endfunction

  // Decide what happens at the edge ending cycle c from the inputs now presented.
  function automatic void model_edge();
    bit    both, fetch_wins;
    comp_t t;
    if (!rst) begin
      model_reset();
    end else if (c >= next_arb && (if_req || d_req)) begin
      both = if_req && d_req;
`ifdef ARB_ROUND_ROBIN_EN
      fetch_wins   = both ? rr_last_data : if_req;
      rr_last_data = !fetch_wins;
`else
      fetch_wins = both ? (starve == STARVE_MAX) : if_req;
      if (both && !fetch_wins) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      else starve = 0;
`endif
      last_iss = c + 1;
      next_arb = c + 1 + MEM_LAT;
      iss_data = !fetch_wins;
      iss_we   = !fetch_wins && d_we;
      exp_addr = fetch_wins ? if_addr : d_addr;
      if (!fetch_wins) exp_wdata = d_wdata;
      t.cyc     = c + 2 + MEM_LAT;
      t.is_data = !fetch_wins;
      t.we      = iss_we;
      t.data    = ref_mem[exp_addr];
      if (iss_we) ref_mem[exp_addr] = d_wdata;
      exp_q.push_back(t);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
    d_wdata = $urandom();
  endtask

  task automatic set_d(input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic cycle();
    bit    e_en, e_ig, e_dg, e_we, e_busy, e_irv, e_drv;
    comp_t t;
    model_edge();
    @(posedge clk);
    c++;
    @(negedge clk);
    e_en   = (last_iss == c);
    e_ig   = e_en && !iss_data;
    e_dg   = e_en && iss_data;
    e_we   = e_en && iss_we;
    e_busy = (c >= last_iss) && (c <= last_iss + MEM_LAT);
    e_irv  = 1'b0;
    e_drv  = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
      t = exp_q.pop_front();
      if (t.is_data) begin
        e_drv = 1'b1;
        if (!t.we) exp_d_rdata = t.data;
      end else begin
        e_irv = 1'b1;
        exp_if_rdata = t.data;
      end
    end
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("busy", busy, e_busy);
    chk("if_rvalid", if_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    // Behavioural single-port memory reacting to the DUT's actual strobes.
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
      else begin
        rd_due = c + MEM_LAT;
        rd_val = mem[mem_addr];
      end
    end
    mem_rdata = (c == rd_due) ? rd_val : $urandom();
    // Requesters react to their grant and may raise new requests.
    if (e_ig) begin
      if (rand_mode ? ($urandom_range(0, 1) == 1) : if_keep) if_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      else if_req = 1'b0;
    end
    if (e_dg) begin
      if (rand_mode ? ($urandom_range(0, 1) == 1) : d_keep) new_d();
      else d_req = 1'b0;
    end
    if (rand_mode) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      if (!d_req && $urandom_range(0, 2) == 0) new_d();
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    bit done;
    while ((if_req || d_req || exp_q.size() > 0 || c <= last_iss + MEM_LAT) && n < lim) begin
      cycle();
      n++;
    end
    done = !(if_req || d_req || exp_q.size() > 0 || c <= last_iss + MEM_LAT);
    chk("drain_bound", done, 1);
  endtask

  task automatic put_mem(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int  nd, k;
    bit  saw;
    logic [WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom();
      mem[i] = v;
      ref_mem[i] = v;
    end
    model_reset();

    // Reset held two cycles with both requests pending.
    if_req = 1'b1; if_addr = 8'h40;
    set_d(1'b0, 8'h30, 32'h0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("first_grant_after_reset", mem_en, 1);
    drain(30);

    // Single fetch.
    put_mem(8'h10, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 8'h10;
    drain(20);
    chk("fetch_deadbeef", if_rdata, 32'hDEADBEEF);

    // Conflict: load and fetch rise together; fetch issues alongside d_rvalid.
    if_req = 1'b1; if_addr = 8'h30;
    set_d(1'b0, 8'h20, 32'h0);
    k = 0;
    do begin cycle(); k++; end while (d_rvalid !== 1'b1 && k < 20);
    chk("conflict_fetch_with_rvalid", if_gnt, 1);
    drain(20);

    // Starvation guard (or alternation when round-robin).
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    d_keep = 1'b1;
    new_d();
    if_req = 1'b1; if_addr = 8'h44;
    nd = 0;
    k = 0;
    do begin
      cycle();
      k++;
      if (d_gnt === 1'b1) nd++;
    end while (if_gnt !== 1'b1 && k < 60);
`ifdef ARB_ROUND_ROBIN_EN
    chk("data_grants_before_fetch", nd, 0);
`else
    chk("data_grants_before_fetch", nd, STARVE_MAX);
`endif
    d_keep = 1'b0;
    drain(30);

    // Store leaves d_rdata at the previous load value.
    put_mem(8'h24, 32'h12345678);
    set_d(1'b0, 8'h24, 32'h0);
    drain(20);
    set_d(1'b1, 8'h20, 32'h55);
    drain(20);
    chk("store_keeps_rdata", d_rdata, 32'h12345678);
    chk("store_written", mem[8'h20], 32'h55);
    set_d(1'b0, 8'h20, 32'h0);
    drain(20);
    chk("load_after_store", d_rdata, 32'h55);

    // Reset in the cycle after a fetch grant abandons it.
    if_req = 1'b1; if_addr = 8'h50;
    k = 0;
    do begin cycle(); k++; end while (if_gnt !== 1'b1 && k < 20);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < MEM_LAT + 3; i++) begin
      cycle();
      if (if_rvalid === 1'b1) saw = 1'b1;
    end
    chk("no_rvalid_after_reset", saw, 0);
    put_mem(8'h04, 32'hCAFE0004);
    set_d(1'b0, 8'h04, 32'h0);
    k = 0;
    do begin cycle(); k++; end while (d_gnt !== 1'b1 && k < 20);
    k = 0;
    do begin cycle(); k++; end while (d_rvalid !== 1'b1 && k < 20);
    chk("load_latency_after_reset", k, MEM_LAT + 1);
    chk("load_data_after_reset", d_rdata, 32'hCAFE0004);
    drain(20);

    // Random traffic with occasional resets.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst = 1'b1;
    rand_mode = 1'b0;
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port unified memory between instruction fetch (IF stage) and data load/store (MEM stage).
- Arbitrates between the two requesters and allows one outstanding access at a time.
- Sequences the fixed-latency memory access and routes the registered response back to the owning requester.
- Sits between the datapath's fetch/memory stages and the memory array inside the cpu top level.

Parameters:
WIDTH, 32, data width of memory words and requester data buses
ADDR_W, 8, word address width
MEM_LAT, 2, cycles from a cycle with mem_en high to valid mem_rdata (range 1..7)
STARVE_MAX, 4, consecutive lost conflicts after which fetch is forced to win (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the clock edge)
if_req  in  1  fetch request; held with if_addr stable until if_gnt seen
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle pulse: fetch access issued this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  WIDTH  fetched instruction word
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt seen
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  WIDTH  store data
d_gnt  out  1  one-cycle pulse: data access issued this cycle
d_rvalid  out  1  one-cycle pulse: load data valid or store completed
d_rdata  out  WIDTH  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  access outstanding (state WAIT)

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; latency counter and starvation counter go to 0.
  - All outputs go to 0, including both rdata buses.
- States:
  - IDLE: no access outstanding.
  - WAIT: an access is outstanding and the latency counter is counting.
- Arbitration happens at the edge ending any IDLE cycle, or the edge ending the final WAIT cycle, when if_req or d_req is high.
- Winner rules:
  - Only one requester high: that requester wins.
  - Both high: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Issue cycle I, following the winning edge:
  - mem_en=1.
  - The winner's gnt=1.
  - mem_addr is the winner's address.
  - For data: mem_we=d_we and mem_wdata=d_wdata. For fetch: mem_we=0.
  - mem_en, mem_we and gnt are high for exactly one cycle.
  - mem_addr and mem_wdata hold their value until the next issue.
  - State becomes WAIT and busy=1.
- Owner: a 1-bit register recording the winner.
- Completion:
  - mem_rdata is sampled at the end of cycle I+MEM_LAT.
  - In cycle I+MEM_LAT+1 the owner's rvalid pulses for one cycle.
  - On a load or fetch, the owner's rdata updates with the sampled value.
  - On a store, d_rvalid pulses and d_rdata is unchanged.
  - rdata of a requester holds its value between its completions.
- Throughput:
  - A new grant may be issued in cycle I+MEM_LAT+1, the same cycle as rvalid.
  - Maximum rate is one access per MEM_LAT+1 cycles.
  - A requester that sees gnt in cycle I must drop req (or present a new request) by cycle I+MEM_LAT.
- Starvation counter (starve_cnt, 4 bits), updated at each arbitration edge:
  - +1 when both requests are high and data wins.
  - Cleared when fetch wins or if_req is low.
  - Saturates at STARVE_MAX.
- No request: the block stays IDLE, and all strobes stay 0.
- Reset mid-operation (rst=0 while in WAIT):
  - The access is abandoned and no rvalid is produced.
  - The next access after reset behaves normally.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On conflicts, the winner is the requester that was not the most recent winner.
  - The last-winner register resets to data, so fetch wins the first conflict after reset.
  - STARVE_MAX and starve_cnt are unused and removed.
- Undefined: data-priority arbitration with starvation guard, as specified above.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with both reqs high -> all outputs 0; rst=1 -> first grant in the cycle after the first arbitration edge.
2. Single fetch: if_addr=0x10, memory returns 0xDEADBEEF -> mem_en=1/mem_addr=0x10/if_gnt=1 in cycle I; if_rvalid=1 with if_rdata=0xDEADBEEF in I+3 (MEM_LAT=2); busy=1 during I..I+2.
3. Conflict: if_req and d_req (load, 0x20) rise together -> d_gnt in I; if_gnt in I+3, same cycle as d_rvalid; no rvalid to the wrong requester.
4. Starvation: d_req held with new addresses and if_req held -> 4 data grants, then if_gnt on the 5th conflict; with ARB_ROUND_ROBIN_EN, grants alternate starting with fetch.
5. Store: d_we=1, d_addr=0x20, d_wdata=0x55 -> mem_we=1/mem_wdata=0x55 for one cycle in I; d_rvalid pulse in I+3; d_rdata keeps its previous load value.
6. Reset mid-access: rst=0 in cycle I+1 of a fetch -> no if_rvalid; after release, a load to 0x04 completes normally in 3 cycles.
